rf_wb_arbiter: RTL and testbench

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_arbiter_if.sv | 26 ++
 rtl/rf_wb_arbiter.sv | 132 +++++++++++++
 tb/tb_rf_wb_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/rf_wb_arbiter_if.sv
// Writeback arbiter bus: ALU and long-latency requests, hazard query, register-file write port.
interface rf_wb_arbiter_if;
  logic        alu_valid;
  logic [4:0]  alu_wr;
  logic [31:0] alu_wd;
  logic        alu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_wr;
  logic [31:0] lsu_wd;
  logic        lsu_ready;
  logic [4:0]  rR1, rR2;
  logic        hz1, hz2;
  logic        we;
  logic [4:0]  wR;
  logic [31:0] wD;

  modport master (
    output alu_valid, alu_wr, alu_wd, lsu_valid, lsu_wr, lsu_wd, rR1, rR2,
    input  alu_ready, lsu_ready, hz1, hz2, we, wR, wD
  );

  modport slave (
    input  alu_valid, alu_wr, alu_wd, lsu_valid, lsu_wr, lsu_wd, rR1, rR2,
    output alu_ready, lsu_ready, hz1, hz2, we, wR, wD
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: ALU priority, FIFO for long-latency writes, starvation guard.
// Optional WB_BYPASS_EN: long-latency write skips an empty queue when the ALU is idle.
module rf_wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  rf_wb_arbiter_if.slave wb
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [4:0]  wr;
    logic [31:0] wd;
  } wb_ent_t;

  wb_ent_t          mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    stv_q, stv_d;
  logic             we_q, we_d;
  logic [4:0]       wr_q, wr_d;
  logic [31:0]      wd_q, wd_d;

  logic starve_hit, alu_acc, lsu_acc, q_empty, deq, enq, byp;

  always_comb begin
    starve_hit   = (stv_q == SW'(STARVE_LIMIT));
    wb.alu_ready = !starve_hit;
    wb.lsu_ready = (cnt_q < CW'(DEPTH));
    alu_acc      = wb.alu_valid && !starve_hit;
    lsu_acc      = wb.lsu_valid && (cnt_q < CW'(DEPTH));
    q_empty      = (cnt_q == '0);
    // Any accepted ALU request owns the output stage, even a discarded index-0 one.
    deq          = !q_empty && !alu_acc;
`ifdef WB_BYPASS_EN
    byp          = lsu_acc && (wb.lsu_wr != 5'd0) && q_empty && !alu_acc;
`else
    byp          = 1'b0;
`endif
    enq          = lsu_acc && (wb.lsu_wr != 5'd0) && !byp;
  end

  // Output-stage selection: ALU first, then queue head, then bypassed transfer.
  always_comb begin
    we_d = 1'b0;
    wr_d = wr_q;
    wd_d = wd_q;
    if (alu_acc) begin
      if (wb.alu_wr != 5'd0) begin
        we_d = 1'b1;
        wr_d = wb.alu_wr;
        wd_d = wb.alu_wd;
      end
    end else if (deq) begin
      we_d = 1'b1;
      wr_d = mem_q[rptr_q].wr;
      wd_d = mem_q[rptr_q].wd;
    end else if (byp) begin
      we_d = 1'b1;
      wr_d = wb.lsu_wr;
      wd_d = wb.lsu_wd;
    end
  end

  always_comb begin
    vld_d  = vld_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q + CW'(enq) - CW'(deq);
    if (deq) begin
      vld_d[rptr_q] = 1'b0;
      rptr_d        = rptr_q + PW'(1);
    end
    if (enq) begin
      vld_d[wptr_q] = 1'b1;
      wptr_d        = wptr_q + PW'(1);
    end
  end

  // Saturates at the limit; the limit cycle always dequeues, which clears it.
  always_comb begin
    stv_d = stv_q;
    if (q_empty || deq)  stv_d = '0;
    else if (!starve_hit) stv_d = stv_q + SW'(1);
  end

  always_comb begin
    wb.hz1 = 1'b0;
    wb.hz2 = 1'b0;
    if (we_q && wr_q == wb.rR1) wb.hz1 = 1'b1;
    if (we_q && wr_q == wb.rR2) wb.hz2 = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && mem_q[i].wr == wb.rR1) wb.hz1 = 1'b1;
      if (vld_q[i] && mem_q[i].wr == wb.rR2) wb.hz2 = 1'b1;
    end
    if (wb.rR1 == 5'd0) wb.hz1 = 1'b0;
    if (wb.rR2 == 5'd0) wb.hz2 = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      vld_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      stv_q  <= '0;
      we_q   <= 1'b0;
      wr_q   <= '0;
      wd_q   <= '0;
    end else begin
      if (enq) mem_q[wptr_q] <= '{wr: wb.lsu_wr, wd: wb.lsu_wd};
      vld_q  <= vld_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      stv_q  <= stv_d;
      we_q   <= we_d;
      wr_q   <= wr_d;
      wd_q   <= wd_d;
    end
  end

  assign wb.we = we_q;
  assign wb.wR = wr_q;
  assign wb.wD = wd_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: ALU path, queue order/full, starvation, hazards, reset.
module tb_rf_wb_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  rf_wb_arbiter_if bus ();
  rf_wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (.clk(clk), .rst_n(rst_n), .wb(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.alu_valid = 0; bus.alu_wr = 0; bus.alu_wd = 0;
    bus.lsu_valid = 0; bus.lsu_wr = 0; bus.lsu_wd = 0;
    bus.rR1 = 5'd3; bus.rR2 = 5'd3;
    #3;
    chk("rst_we", bus.we, 0);
    chk("rst_wR", bus.wR, 0);
    chk("rst_wD", bus.wD, 0);
    chk("rst_lsu_ready", bus.lsu_ready, 1);
    chk("rst_alu_ready", bus.alu_ready, 1);
    chk("rst_hz1", bus.hz1, 0);
    step(); step();
    rst_n = 1;

    // ALU write appears the next cycle only
    bus.alu_valid = 1; bus.alu_wr = 5'd5; bus.alu_wd = 32'h1234;
    #1 chk("alu_ready", bus.alu_ready, 1);
    step();
    chk("alu_we", bus.we, 1);
    chk("alu_wR", bus.wR, 5);
    chk("alu_wD", bus.wD, 32'h1234);
    bus.rR1 = 5'd5;
    #1 chk("alu_hz_out", bus.hz1, 1);
    bus.alu_valid = 0;
    step();
    chk("alu_we_once", bus.we, 0);
    chk("hold_wR", bus.wR, 5);
    chk("hold_wD", bus.wD, 32'h1234);

    // index 0 ALU request discarded
    bus.alu_valid = 1; bus.alu_wr = 5'd0; bus.alu_wd = 32'hFFFF; bus.rR1 = 5'd0;
    step();
    chk("zero_alu_we", bus.we, 0);
    chk("zero_alu_wD", bus.wD, 32'h1234);
    chk("zero_hz1", bus.hz1, 0);
    bus.alu_valid = 0;
    step();
    chk("zero_alu_we2", bus.we, 0);

    // Fill queue behind a busy ALU, then drain in order
    bus.alu_valid = 1; bus.alu_wr = 5'd10; bus.alu_wd = 32'hA;
    bus.lsu_valid = 1;
    for (int i = 1; i <= 4; i++) begin
      bus.lsu_wr = 5'(i); bus.lsu_wd = 32'h11 * i;
      #1 chk("fill_lsu_ready", bus.lsu_ready, 1);
      step();
      chk("fill_alu_wR", bus.wR, 10);
    end
    bus.rR1 = 5'd3; bus.rR2 = 5'd4;
    #1;
    chk("full_lsu_ready", bus.lsu_ready, 0);
    chk("q_hz1", bus.hz1, 1);
    chk("q_hz2", bus.hz2, 1);
    bus.alu_valid = 0; bus.lsu_wr = 5'd15; bus.lsu_wd = 32'hF;
    for (int i = 1; i <= 4; i++) begin
      step();
      bus.lsu_valid = 0;
      chk("drain_we", bus.we, 1);
      chk("drain_wR", bus.wR, 32'(i));
      chk("drain_wD", bus.wD, 32'h11 * i);
    end
    step();
    chk("drain_done_we", bus.we, 0);
    chk("drain_hold_wR", bus.wR, 4);
    chk("drain_hz1", bus.hz1, 0);
    step();
    chk("no_full_enq", bus.we, 0);

    // Starvation: head forces one ALU stall after 8 waiting cycles
    bus.alu_valid = 1; bus.alu_wr = 5'd6; bus.alu_wd = 32'h66;
    bus.lsu_valid = 1; bus.lsu_wr = 5'd7; bus.lsu_wd = 32'h77;
    step();
    bus.lsu_valid = 0; bus.rR1 = 5'd7;
    for (int i = 0; i < 8; i++) begin
      #1 chk("stv_alu_ready", bus.alu_ready, 1);
      step();
      chk("stv_alu_wR", bus.wR, 6);
    end
    chk("stv_hz1", bus.hz1, 1);
    chk("stv_stall", bus.alu_ready, 0);
    step();
    chk("stv_commit_we", bus.we, 1);
    chk("stv_commit_wR", bus.wR, 7);
    chk("stv_commit_wD", bus.wD, 32'h77);
    chk("stv_ready_back", bus.alu_ready, 1);
    step();
    chk("stv_resume_wR", bus.wR, 6);
    bus.alu_valid = 0;
    step();
    chk("stv_idle_we", bus.we, 0);

    // Hazard on a queued entry clears the cycle after its commit
    bus.rR2 = 5'd9;
    bus.alu_valid = 1;
    bus.lsu_valid = 1; bus.lsu_wr = 5'd9; bus.lsu_wd = 32'h99;
    step();
    bus.lsu_valid = 0;
    #1 chk("hz2_queued", bus.hz2, 1);
    step();
    chk("hz2_wait", bus.hz2, 1);
    bus.alu_valid = 0;
    step();
    chk("hz2_commit_wR", bus.wR, 9);
    chk("hz2_commit", bus.hz2, 1);
    step();
    chk("hz2_clear", bus.hz2, 0);

    // Queue latency (direct with bypass)
    bus.lsu_valid = 1; bus.lsu_wr = 5'd20; bus.lsu_wd = 32'h2020;
    step();
    bus.lsu_valid = 0;
`ifdef WB_BYPASS_EN
    chk("lat_n1_we", bus.we, 1);
    step();
    chk("lat_n2_we", bus.we, 0);
`else
    chk("lat_n1_we", bus.we, 0);
    step();
    chk("lat_n2_we", bus.we, 1);
`endif
    chk("lat_wR", bus.wR, 20);

    // index 0 long-latency transfer discarded
    bus.lsu_valid = 1; bus.lsu_wr = 5'd0; bus.lsu_wd = 32'hDEAD;
    step();
    bus.lsu_valid = 0;
    chk("zero_lsu_we", bus.we, 0);
    step();
    chk("zero_lsu_we2", bus.we, 0);
    chk("zero_lsu_wD", bus.wD, 32'h2020);

    // Mid-cycle reset drops queued writes
    bus.alu_valid = 1; bus.alu_wr = 5'd6;
    bus.lsu_valid = 1; bus.lsu_wr = 5'd12; bus.lsu_wd = 32'hC;
    step();
    bus.lsu_wr = 5'd13;
    step();
    bus.lsu_valid = 0; bus.rR1 = 5'd12;
    #1 chk("pre_rst_hz1", bus.hz1, 1);
    #1 rst_n = 0;
    #1;
    chk("mid_rst_we", bus.we, 0);
    chk("mid_rst_wR", bus.wR, 0);
    chk("mid_rst_lsu_ready", bus.lsu_ready, 1);
    chk("mid_rst_hz1", bus.hz1, 0);
    bus.alu_valid = 0;
    step(); step();
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_rst_we", bus.we, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
